psum_line_reducer: RTL and testbench

- Downstream consumer of the three-line psum RAM read port.
- Sweeps a programmed address range in three-line mode, adds the three line outputs element-wise per time step and emits one reduced word per address on a valid/ready stream toward the spike/LIF stage.
- Handles the fixed two-cycle RAM read latency with credit-based flow control, so backpressure never drops or duplicates data.

---
 rtl/psum_line_reducer.sv | 177 +++++++++++++++++
 tb/tb_psum_line_reducer.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/psum_line_reducer.sv
// Reads a range of three-line psum RAM words, sums the lines per time step and streams one result per address.
// Define PSUM_REDUCE_SAT_EN to saturate each sum to ERS_W bits behind one extra pipeline register.
module psum_line_reducer #(
  parameter int ERS_W      = 21,
  parameter int T_STEPS    = 4,
  parameter int ADDR_W     = 9,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          s_clk,
  input  logic                          s_rst_n,
  input  logic                          start,
  input  logic [ADDR_W-1:0]             base_addr,
  input  logic [ADDR_W:0]               rd_len,
  output logic                          busy,
  output logic                          done,
  output logic                          psum_rd_req,
  output logic [ADDR_W-1:0]             psum_rd_addr,
  input  logic [ERS_W*T_STEPS-1:0]      psum_line0,
  input  logic [ERS_W*T_STEPS-1:0]      psum_line1,
  input  logic [ERS_W*T_STEPS-1:0]      psum_line2,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [(ERS_W+2)*T_STEPS-1:0]  m_data,
  output logic                          m_last
);
  localparam int OW    = ERS_W + 2;
  localparam int IW    = ERS_W * T_STEPS;
  localparam int DW    = OW * T_STEPS;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t                state_q, state_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [ADDR_W:0]       remain_q, remain_d;
  logic [1:0]            vld_q, last_q;
  logic [1:0]            inflight_q, inflight_d;
  logic [DW-1:0]         mem_q [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] mlast_q;
  logic [PTR_W-1:0]      wptr_q, rptr_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [CNT_W:0]        occ;
  logic                  issue, pop, drained;
  logic                  wr_en, wr_last;
  logic [DW-1:0]         wr_data, sum_c;

`ifdef PSUM_REDUCE_SAT_EN
  localparam logic [OW-1:0] SAT_MAX = {3'b000, {(ERS_W-1){1'b1}}};
  localparam logic [OW-1:0] SAT_MIN = {3'b111, {(ERS_W-1){1'b0}}};
`endif

  // Sign-extended three-way add is exact in ERS_W+2 bits.
  function automatic logic [DW-1:0] reduce3(input logic [IW-1:0] a, input logic [IW-1:0] b,
                                            input logic [IW-1:0] c);
    logic [DW-1:0] r;
    logic [OW-1:0] s;
    r = '0;
    for (int t = 0; t < T_STEPS; t++) begin
      s = {{2{a[t*ERS_W+ERS_W-1]}}, a[t*ERS_W +: ERS_W]}
        + {{2{b[t*ERS_W+ERS_W-1]}}, b[t*ERS_W +: ERS_W]}
        + {{2{c[t*ERS_W+ERS_W-1]}}, c[t*ERS_W +: ERS_W]};
`ifdef PSUM_REDUCE_SAT_EN
      if ($signed(s) > $signed(SAT_MAX)) s = SAT_MAX;
      else if ($signed(s) < $signed(SAT_MIN)) s = SAT_MIN;
`endif
      r[t*OW +: OW] = s;
    end
    return r;
  endfunction

  assign sum_c = reduce3(psum_line0, psum_line1, psum_line2);

`ifdef PSUM_REDUCE_SAT_EN
  logic [DW-1:0] sum_q;
  logic          svld_q, slast_q;

  always_ff @(posedge s_clk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      sum_q   <= '0;
      svld_q  <= 1'b0;
      slast_q <= 1'b0;
    end else begin
      if (vld_q[1]) sum_q <= sum_c;
      svld_q  <= vld_q[1];
      slast_q <= last_q[1];
    end
  end

  assign wr_en   = svld_q;
  assign wr_data = sum_q;
  assign wr_last = slast_q;
`else
  assign wr_en   = vld_q[1];
  assign wr_data = sum_c;
  assign wr_last = last_q[1];
`endif

  assign pop = (cnt_q != '0) && m_ready;

  // A read is issued only when its result is guaranteed a FIFO slot, so writes never stall.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    remain_d   = remain_q;
    issue      = 1'b0;
    occ        = (CNT_W+1)'(inflight_q) + (CNT_W+1)'(cnt_q);
    drained    = (inflight_q == 2'd0) &&
                 ((cnt_q == '0) || ((cnt_q == CNT_W'(1)) && pop));
    case (state_q)
      IDLE: begin
        if (start) begin
          addr_d   = base_addr;
          remain_d = rd_len;
          state_d  = (rd_len == '0) ? DONE : ISSUE;
        end
      end
      ISSUE: begin
        if (occ < (CNT_W+1)'(FIFO_DEPTH)) begin
          issue    = 1'b1;
          addr_d   = addr_q + 1'b1;
          remain_d = remain_q - 1'b1;
          if (remain_q == (ADDR_W+1)'(1)) state_d = DRAIN;
        end
      end
      DRAIN:   if (drained) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    inflight_d = inflight_q + 2'(issue) - 2'(wr_en);
  end

  always_ff @(posedge s_clk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      remain_q   <= '0;
      inflight_q <= '0;
      vld_q      <= '0;
      last_q     <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      remain_q   <= remain_d;
      inflight_q <= inflight_d;
      vld_q      <= {vld_q[0], issue};
      last_q     <= {last_q[0], issue && (remain_q == (ADDR_W+1)'(1))};
    end
  end

  always_ff @(posedge s_clk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      mlast_q <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
    end else begin
      if (wr_en) begin
        mem_q[wptr_q]   <= wr_data;
        mlast_q[wptr_q] <= wr_last;
        wptr_q          <= wptr_q + 1'b1;
      end
      if (pop) rptr_q <= rptr_q + 1'b1;
      cnt_q <= cnt_q + CNT_W'(wr_en) - CNT_W'(pop);
    end
  end

  assign busy         = (state_q == ISSUE) || (state_q == DRAIN);
  assign done         = (state_q == DONE);
  assign psum_rd_req  = issue;
  assign psum_rd_addr = addr_q;
  assign m_valid      = (cnt_q != '0);
  assign m_data       = mem_q[rptr_q];
  assign m_last       = m_valid && mlast_q[rptr_q];

endmodule

// File: tb/tb_psum_line_reducer.sv
// Self-checking bench for psum_line_reducer: a two-cycle RAM model plus an address-level scoreboard
// of expected sums; honours PSUM_REDUCE_SAT_EN in its reference model.
module tb_psum_line_reducer;
  localparam int EW = 21;
  localparam int OW = 23;
  localparam int IW = 84;
  localparam int DW = 92;
  localparam int DEPTH = 4;
`ifdef PSUM_REDUCE_SAT_EN
  localparam int FIRST_LAT = 4;
`else
  localparam int FIRST_LAT = 3;
`endif

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  logic          s_clk, s_rst_n, start, busy, done, psum_rd_req, m_valid, m_ready, m_last;
  logic [8:0]    base_addr, psum_rd_addr;
  logic [9:0]    rd_len;
  logic [IW-1:0] psum_line0, psum_line1, psum_line2;
  logic [DW-1:0] m_data;

  logic [IW-1:0] ram0 [512];
  logic [IW-1:0] ram1 [512];
  logic [IW-1:0] ram2 [512];
  logic [8:0]    rdA1 = '0, rdA2 = '0;

  beat_t         expQ[$];
  int            addrQ[$];
  int            vectors = 0, miscompares = 0;
  int            cyc = 0, sc = 0, readyMode = 0;
  int            issued = 0, accepted = 0, doneCount = 0;
  int            startCyc, doneCyc, firstReqCyc, lastReqCyc, firstValidCyc, lastAcceptCyc;
  logic          pvValid = 1'b0, pvLast = 1'b0;
  logic [DW-1:0] pvData = '0, lastData = '0;

  psum_line_reducer dut (
    .s_clk(s_clk), .s_rst_n(s_rst_n), .start(start), .base_addr(base_addr), .rd_len(rd_len),
    .busy(busy), .done(done), .psum_rd_req(psum_rd_req), .psum_rd_addr(psum_rd_addr),
    .psum_line0(psum_line0), .psum_line1(psum_line1), .psum_line2(psum_line2),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last)
  );

  initial s_clk = 1'b0;
  always #5 s_clk = ~s_clk;

  // RAM model: data for an address appears two cycles after it is presented.
  always @(posedge s_clk) begin
    rdA1 <= psum_rd_addr;
    rdA2 <= rdA1;
  end
  assign psum_line0 = ram0[rdA2];
  assign psum_line1 = ram1[rdA2];
  assign psum_line2 = ram2[rdA2];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] expBeat(input int a);
    logic [DW-1:0] r;
    logic [EW-1:0] x0, x1, x2;
    int s;
    r = '0;
    for (int t = 0; t < 4; t++) begin
      x0 = ram0[a][t*EW +: EW];
      x1 = ram1[a][t*EW +: EW];
      x2 = ram2[a][t*EW +: EW];
      s  = int'($signed(x0)) + int'($signed(x1)) + int'($signed(x2));
`ifdef PSUM_REDUCE_SAT_EN
      if (s > 1048575) s = 1048575;
      if (s < -1048576) s = -1048576;
`endif
      r[t*OW +: OW] = OW'(s);
    end
    return r;
  endfunction

  task automatic fillPattern(input int base, input int len, input int mode);
    int a;
    logic [EW-1:0] v;
    for (int i = 0; i < len; i++) begin
      a = (base + i) % 512;
      for (int t = 0; t < 4; t++) begin
        if (mode == 0) begin
          v = EW'(a);
          ram0[a][t*EW +: EW] = v; ram1[a][t*EW +: EW] = v; ram2[a][t*EW +: EW] = v;
        end else if (mode == 1) begin
          v = 21'h100000;
          ram0[a][t*EW +: EW] = v; ram1[a][t*EW +: EW] = v; ram2[a][t*EW +: EW] = v;
        end else begin
          ram0[a][t*EW +: EW] = ($urandom % 4 == 0) ? 21'h100000 : EW'($urandom);
          ram1[a][t*EW +: EW] = ($urandom % 4 == 0) ? 21'h0FFFFF : EW'($urandom);
          ram2[a][t*EW +: EW] = EW'($urandom);
        end
      end
    end
  endtask

  task automatic checkIdle(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_req"}, psum_rd_req, 0);
    chk({tag, "_addr"}, psum_rd_addr, 0);
    chk({tag, "_valid"}, m_valid, 0);
    chk({tag, "_last"}, m_last, 0);
    chk({tag, "_data"}, m_data, 0);
  endtask

  // One cycle: settle beat accepted at the edge just passed, then sample this cycle's outputs.
  task automatic tick();
    beat_t e;
    @(negedge s_clk);
    cyc++;
    sc++;
    if (pvValid && m_ready) begin
      if (expQ.size() == 0) chk("unexpected_beat", 1, 0);
      else begin
        e = expQ.pop_front();
        chk("beat_data", pvData, e.data);
        chk("beat_last", pvLast, e.last);
      end
      lastData = pvData;
      accepted++;
      lastAcceptCyc = cyc - 1;
    end else if (pvValid) begin
      chk("stall_valid", m_valid, 1);
      chk("stall_data", m_data, pvData);
      chk("stall_last", m_last, pvLast);
    end
    pvValid = m_valid;
    pvData  = m_data;
    pvLast  = m_last;
    if (m_valid && firstValidCyc < 0) firstValidCyc = cyc;
    if (psum_rd_req) begin
      if (addrQ.size() == 0) chk("unexpected_req", 1, 0);
      else chk("req_addr", psum_rd_addr, addrQ.pop_front());
      issued++;
      if (firstReqCyc < 0) firstReqCyc = cyc;
      lastReqCyc = cyc;
      chk("credit_bound", (issued - accepted) <= DEPTH, 1);
    end
    if (done) begin
      doneCount++;
      doneCyc = cyc;
    end
    case (readyMode)
      1:       m_ready = 1'($urandom_range(0, 1));
      2:       m_ready = !(sc >= 3 && sc <= 12);
      default: m_ready = 1'b1;
    endcase
  endtask

  task automatic runSweep(input int base, input int len, input int budget, input int extraAt);
    int a, n, d0;
    for (int i = 0; i < len; i++) begin
      a = (base + i) % 512;
      addrQ.push_back(a);
      expQ.push_back('{data: expBeat(a), last: (i == len - 1)});
    end
    issued = 0; accepted = 0;
    firstReqCyc = -1; firstValidCyc = -1; lastReqCyc = -1; lastAcceptCyc = -1; doneCyc = -1;
    d0 = doneCount;
    base_addr = 9'(base);
    rd_len    = 10'(len);
    start     = 1'b1;
    startCyc  = cyc;
    sc        = 0;
    tick();
    start = 1'b0;
    if (len != 0) chk("busy_after_start", busy, 1);
    n = 0;
    while (doneCount == d0 && n < budget) begin
      if (n == extraAt) begin
        base_addr = 9'd100;
        rd_len    = 10'd3;
        start     = 1'b1;
      end
      tick();
      start = 1'b0;
      n++;
    end
    chk("done_seen", doneCount != d0, 1);
    chk("all_beats", expQ.size(), 0);
    chk("all_reqs", addrQ.size(), 0);
    tick();
    chk("busy_cleared", busy, 0);
    chk("done_single_cycle", done, 0);
    repeat (3) tick();
    chk("one_done", doneCount - d0, 1);
  endtask

  initial begin
    int n;
    s_rst_n = 1'b0; start = 1'b0; base_addr = '0; rd_len = '0; m_ready = 1'b1;
    repeat (3) @(negedge s_clk);
    checkIdle("reset");
    s_rst_n = 1'b1;
    tick();

    $display("[TB] basic sweep");
    fillPattern(10, 4, 0);
    runSweep(10, 4, 60, -1);
    chk("basic_last_elem0", lastData[OW-1:0], 39);
    chk("basic_first_valid_lat", firstValidCyc - firstReqCyc, FIRST_LAT);
    chk("basic_done_after_accept", doneCyc - lastAcceptCyc, 1);
`ifndef PSUM_REDUCE_SAT_EN
    chk("basic_consecutive_reqs", lastReqCyc - firstReqCyc, 3);
`endif

    $display("[TB] signed extremes");
    fillPattern(20, 3, 1);
    runSweep(20, 3, 60, -1);
`ifdef PSUM_REDUCE_SAT_EN
    chk("extreme_elem0", lastData[OW-1:0], 23'h700000);
    chk("extreme_elem3", lastData[3*OW +: OW], 23'h700000);
`else
    chk("extreme_elem0", lastData[OW-1:0], 23'h500000);
    chk("extreme_elem3", lastData[3*OW +: OW], 23'h500000);
`endif

    $display("[TB] backpressure");
    fillPattern(50, 10, 2);
    readyMode = 2;
    runSweep(50, 10, 120, -1);

    $display("[TB] wrap with random ready");
    fillPattern(510, 4, 2);
    readyMode = 1;
    runSweep(510, 4, 120, -1);
    readyMode = 0;

    $display("[TB] zero length");
    runSweep(5, 0, 10, -1);
    chk("zero_no_reqs", issued, 0);
    chk("zero_done_timing", (doneCyc - startCyc) >= 1 && (doneCyc - startCyc) <= 2, 1);

    $display("[TB] start while busy");
    fillPattern(40, 6, 2);
    fillPattern(100, 3, 2);
    runSweep(40, 6, 80, 2);

    $display("[TB] reset mid-sweep");
    fillPattern(300, 8, 2);
    for (int i = 0; i < 8; i++) begin
      addrQ.push_back(300 + i);
      expQ.push_back('{data: expBeat(300 + i), last: (i == 7)});
    end
    issued = 0; accepted = 0;
    base_addr = 9'd300; rd_len = 10'd8; start = 1'b1; sc = 0;
    tick();
    start = 1'b0;
    n = 0;
    while (accepted < 3 && n < 60) begin
      tick();
      n++;
    end
    chk("rst_three_beats", accepted >= 3, 1);
    #2 s_rst_n = 1'b0;
    #1 checkIdle("async_rst");
    expQ.delete(); addrQ.delete();
    pvValid = 1'b0; issued = 0; accepted = 0;
    n = doneCount;
    tick();
    s_rst_n = 1'b1;
    repeat (4) tick();
    chk("rst_no_done", doneCount - n, 0);
    chk("rst_idle_valid", m_valid, 0);
    chk("rst_idle_busy", busy, 0);
    fillPattern(200, 2, 2);
    runSweep(200, 2, 40, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
